// File: rtl/dbus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// dbus_bridge_pkg
// Shared definitions for the core data-bus to memory bridge:
//   - FSM state encoding (IDLE / REQ / DONE)
//   - default timeout and error-data constants
//   - latched request record and word-alignment helper
// ---------------------------------------------------------------------------
package dbus_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int          DEFAULT_TIMEOUT  = 255;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hFFFF_FFFF;

  // Counter width covers the largest legal TIMEOUT (65535).
  localparam int CNT_W = 16;

  // Access captured in IDLE and held stable for the whole REQ phase.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } dbus_req_t;

  // Memory side only sees word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dbus_timeout.sv
// ---------------------------------------------------------------------------
// dbus_timeout
// Loadable up-counter with a terminal-count flag, used to bound how long the
// bridge waits for a memory acknowledge.
// Ports:
//   clk      in   clock
//   res      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val (has priority over inc)
//   load_val in   value to load
//   inc      in   increment by one
//   tc       out  count equals TC_VALUE
// ---------------------------------------------------------------------------
module dbus_timeout
  import dbus_bridge_pkg::*;
#(
  parameter logic [CNT_W-1:0] TC_VALUE = 16'd254
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic             tc
);

  logic [CNT_W-1:0] count_r;

  // Wait-cycle counter
  always_ff @(posedge clk) begin
    if (res) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (inc) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TC_VALUE);

endmodule

// File: rtl/dbus_bridge.sv
// ---------------------------------------------------------------------------
// dbus_bridge
// Bridges a single-cycle core data port onto a request/acknowledge memory
// bus. The core is frozen through `halt` while an access is in flight; the
// result is presented on core_rdata in the DONE cycle, where halt drops so the
// core retires the access. Accesses with no acknowledge after TIMEOUT REQ
// cycles are force-completed, return ERR_DATA (loads) and set a sticky err.
// Ports:
//   clk, res                   clock, synchronous active-high reset
//   core_addr/wdata/be/re/we   core access request
//   core_rdata                 load data (read register)
//   dbg_halt                   external halt, ORed into halt
//   halt                       combinational stall to the core
//   mem_req/we/addr/wdata/be   memory request, held until acknowledged
//   mem_rdata, mem_ack         memory response
//   err                        sticky timeout flag
// ---------------------------------------------------------------------------
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_be,
  input  logic        core_re,
  input  logic        core_we,
  output logic [31:0] core_rdata,
  input  logic        dbg_halt,
  output logic        halt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  // Timed out when the counter shows TIMEOUT-1 in a REQ cycle without ack,
  // i.e. after exactly TIMEOUT REQ cycles.
  localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT - 1);

  logic [1:0]  state_r;
  logic [1:0]  next_state_s;
  dbus_req_t   req_r;
  logic        mem_req_r;
  logic [31:0] rdata_r;
  logic        err_r;

  logic access_s;
  logic start_s;
  logic ack_s;
  logic tmo_s;
  logic done_s;
  logic cnt_load_s;
  logic cnt_inc_s;
  logic tc_s;

  assign access_s = core_re | core_we;
  assign start_s  = (state_r == ST_IDLE) & access_s & ~dbg_halt;
  // mem_ack is only meaningful while a request is outstanding.
  assign ack_s    = (state_r == ST_REQ) & mem_ack;
  assign tmo_s    = (state_r == ST_REQ) & ~mem_ack & tc_s;
  assign done_s   = ack_s | tmo_s;

  // Counter is held at zero outside REQ and cleared on completion.
  assign cnt_load_s = (state_r != ST_REQ) | done_s;
  assign cnt_inc_s  = (state_r == ST_REQ) & ~done_s;

  dbus_timeout #(
    .TC_VALUE (TC_VALUE)
  ) u_timeout (
    .clk      (clk),
    .res      (res),
    .load     (cnt_load_s),
    .load_val ({CNT_W{1'b0}}),
    .inc      (cnt_inc_s),
    .tc       (tc_s)
  );

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          next_state_s = ST_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (done_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request latch and registered mem_req (high exactly while in REQ)
  always_ff @(posedge clk) begin
    if (res) begin
      req_r     <= '0;
      mem_req_r <= 1'b0;
    end else begin
      if (start_s) begin
        // A simultaneous load+store is issued as a store.
        req_r <= '{addr:  word_align(core_addr),
                   wdata: core_wdata,
                   be:    core_be,
                   we:    core_we};
      end else begin
        req_r <= req_r;
      end
      mem_req_r <= (next_state_s == ST_REQ);
    end
  end

  // Read register: only loads update it; stores return nothing, even when
  // they time out.
  always_ff @(posedge clk) begin
    if (res) begin
      rdata_r <= 32'h0000_0000;
    end else if (ack_s & ~req_r.we) begin
      rdata_r <= mem_rdata;
    end else if (tmo_s & ~req_r.we) begin
      rdata_r <= ERR_DATA;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (res) begin
      err_r <= 1'b0;
    end else if (tmo_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // halt is combinational so the core freezes on the same edge the access is
  // presented; reset forces it low.
  assign halt = ~res & (dbg_halt
                        | ((state_r == ST_IDLE) & access_s)
                        | (state_r == ST_REQ));

  assign mem_req    = mem_req_r;
  assign mem_we     = req_r.we;
  assign mem_addr   = req_r.addr;
  assign mem_wdata  = req_r.wdata;
  assign mem_be     = req_r.be;
  assign core_rdata = rdata_r;
  assign err        = err_r;

endmodule

// File: tb/tb_dbus_bridge.sv
// ---------------------------------------------------------------------------
// tb_dbus_bridge
// Cycle-by-cycle vector table for dbus_bridge (TIMEOUT=4), followed by
// hand-written timeout and reset-mid-request sequences.
// Inputs are applied at the falling edge and outputs compared 2 time units
// later, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_dbus_bridge;

  logic        clk;
  logic        res;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_be;
  logic        core_re;
  logic        core_we;
  logic [31:0] core_rdata;
  logic        dbg_halt;
  logic        halt;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int total = 0;
  int bad   = 0;

  dbus_bridge #(
    .TIMEOUT  (4),
    .ERR_DATA (32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .res        (res),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_be    (core_be),
    .core_re    (core_re),
    .core_we    (core_we),
    .core_rdata (core_rdata),
    .dbg_halt   (dbg_halt),
    .halt       (halt),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        res;
    logic        re;
    logic        we;
    logic        dh;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rin;
    logic        e_halt;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic r, input logic re, input logic we, input logic dh,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic ack, input logic [31:0] rin,
                     input logic eh, input logic erq, input logic ewe,
                     input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] ebe,
                     input logic [31:0] erd, input logic eer);
    vec_t v;
    v.res = r; v.re = re; v.we = we; v.dh = dh; v.addr = a; v.wdata = wd; v.be = be;
    v.ack = ack; v.rin = rin; v.e_halt = eh; v.e_req = erq; v.e_we = ewe;
    v.e_addr = ea; v.e_wdata = ewd; v.e_be = ebe; v.e_rdata = erd; v.e_err = eer;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic re, input logic we, input logic dh,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic ack, input logic [31:0] rin);
    res = r; core_re = re; core_we = we; dbg_halt = dh; core_addr = a;
    core_wdata = wd; core_be = be; mem_ack = ack; mem_rdata = rin;
  endtask

  initial begin
    int n;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);

    //   res   re    we    dh    addr          wdata         be    ack   rin              halt  req   we    addr          wdata         be    rdata         err
    // reset holds halt low even with a load pending
    row(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0);
    // zero-wait load at 0x104
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'hF, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'hF, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0,       4'hF, 32'h0,        1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    // stale ack in IDLE is ignored
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    // store with 3 wait cycles, ack lands on the last cycle before timeout
    row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h00AB_0000, 4'h4, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h00AB_0000, 4'h4, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h00AB_0000, 4'h4, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h00AB_0000, 4'h4, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h00AB_0000, 4'h4, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 1'b1, 32'h5555_5555, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h00AB_0000, 4'h4, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h00AB_0000, 4'h4, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    // load+store together is a store
    row(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_BEEF, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_BEEF, 4'hF, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_BEEF, 4'hF, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    // dbg_halt with no access, then with an access pending: no request issued
    row(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0,        4'hF, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    // back-to-back loads at 0x0 and 0x8
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        4'hF, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        4'hF, 1'b1, 32'h0000_0A0A, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,      4'hF, 32'hCAFE_F00D, 1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,        4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_0A0A, 1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,        4'hF, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_0A0A, 1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,        4'hF, 1'b1, 32'h0000_0B0B, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,      4'hF, 32'h0000_0A0A, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_0B0B, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_0B0B, 1'b0);
    // dbg_halt raised mid-REQ does not abort; halt stays high in DONE
    row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0,        4'hF, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_0B0B, 1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0,        4'hF, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0,      4'hF, 32'h0000_0B0B, 1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0,        4'hF, 1'b1, 32'h3030_3030, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0,      4'hF, 32'h0000_0B0B, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h3030_3030, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h3030_3030, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h3030_3030, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].res, vq[i].re, vq[i].we, vq[i].dh, vq[i].addr, vq[i].wdata,
            vq[i].be, vq[i].ack, vq[i].rin);
      #2;
      chk($sformatf("row%0d halt", i),    {31'd0, halt},    {31'd0, vq[i].e_halt});
      chk($sformatf("row%0d mem_req", i), {31'd0, mem_req}, {31'd0, vq[i].e_req});
      chk($sformatf("row%0d rdata", i),   core_rdata,       vq[i].e_rdata);
      chk($sformatf("row%0d err", i),     {31'd0, err},     {31'd0, vq[i].e_err});
      if (vq[i].e_req) begin
        chk($sformatf("row%0d mem_we", i),    {31'd0, mem_we}, {31'd0, vq[i].e_we});
        chk($sformatf("row%0d mem_addr", i),  mem_addr,        vq[i].e_addr);
        chk($sformatf("row%0d mem_wdata", i), mem_wdata,       vq[i].e_wdata);
        chk($sformatf("row%0d mem_be", i),    {28'd0, mem_be}, {28'd0, vq[i].e_be});
      end
      @(negedge clk);
    end

    // Timeout: load at 0x40 never acknowledged, TIMEOUT=4
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 32'h0);
    #2;
    chk("tmo idle halt", {31'd0, halt}, 32'd1);
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      #2;
      if (mem_req !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    chk("tmo req cycles", n, 32'd4);
    chk("tmo done halt", {31'd0, halt}, 32'd0);
    chk("tmo rdata", core_rdata, 32'hFFFF_FFFF);
    chk("tmo err", {31'd0, err}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("tmo err sticky%0d", k), {31'd0, err}, 32'd1);
      chk($sformatf("tmo idle req%0d", k), {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end
    // a successful load afterwards leaves err set
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 1'b1, 32'h4444_4444);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    #2;
    chk("post tmo rdata", core_rdata, 32'h4444_4444);
    chk("post tmo err", {31'd0, err}, 32'd1);
    @(negedge clk);

    // Reset in the second REQ cycle, stale ack afterwards
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0050, 32'h0, 4'hF, 1'b0, 32'h0);
    #2;
    chk("rst idle halt", {31'd0, halt}, 32'd1);
    @(negedge clk);
    #2;
    chk("rst req1 mem_req", {31'd0, mem_req}, 32'd1);
    chk("rst req1 addr", mem_addr, 32'h0000_0050);
    @(negedge clk);
    res = 1'b1;
    #2;
    chk("rst active halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h7777_7777);
    #2;
    chk("rst after mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst after halt", {31'd0, halt}, 32'd0);
    chk("rst after rdata", core_rdata, 32'h0);
    chk("rst after err", {31'd0, err}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #2;
    chk("rst stale mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst stale halt", {31'd0, halt}, 32'd0);
    chk("rst stale rdata", core_rdata, 32'h0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
